// File: rtl/hazard_controller.sv
// -----------------------------------------------------------------------------
// hazard_controller
//
// Central pipeline sequencer for the 5-stage core. Each cycle it decides
// whether fetch/decode stall, whether a bubble enters execute, whether
// fetch/decode are squashed after a taken branch, and whether the core is
// frozen after a halt retires. Also keeps saturating stall/flush counters.
//
// State table
//   state       | meaning
//   ------------+-----------------------------------------------------------
//   ST_RUN      | normal flow; load-use hazards are detected here
//   ST_LU_STALL | extra load-use bubble cycles (LOAD_USE_CYCLES > 1)
//   ST_FLUSH    | extra squash cycles after a taken branch (FLUSH_CYCLES > 1)
//   ST_HALT     | halt retired; core frozen until reset
//
// Ports
//   clk                      core clock
//   rst                      asynchronous reset, active low
//   id_valid                 decode holds a real instruction
//   id_rs1_addr/id_rs1_used  decode rs1 address / rs1 is read
//   id_rs2_addr/id_rs2_used  decode rs2 address / rs2 is read
//   ex_rd_addr/ex_w_enable   execute destination register / writes rd
//   ex_is_load               execute instruction is a load
//   ex_br_taken/ex_br_target taken branch resolved in execute / its target
//   dmem_busy                data memory not ready, whole pipe holds
//   wb_is_halt               halt instruction retiring in writeback
//   stall_fetch/decode/execute  hold the respective pipeline registers
//   is_data_hazard           insert a NOP into the execute pipe register
//   flush_fetch/flush_decode squash fetch / decode outputs
//   redirect_valid/redirect_pc  load redirect_pc into the PC this cycle
//   halted                   core is halted
//   stall_cnt/flush_cnt      saturating perf counters
// -----------------------------------------------------------------------------
module hazard_controller #(
  parameter int LOAD_USE_CYCLES = 1,
  parameter int FLUSH_CYCLES    = 2,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 id_valid,
  input  logic [4:0]           id_rs1_addr,
  input  logic                 id_rs1_used,
  input  logic [4:0]           id_rs2_addr,
  input  logic                 id_rs2_used,
  input  logic [4:0]           ex_rd_addr,
  input  logic                 ex_w_enable,
  input  logic                 ex_is_load,
  input  logic                 ex_br_taken,
  input  logic [31:0]          ex_br_target,
  input  logic                 dmem_busy,
  input  logic                 wb_is_halt,
  output logic                 stall_fetch,
  output logic                 stall_decode,
  output logic                 stall_execute,
  output logic                 is_data_hazard,
  output logic                 flush_fetch,
  output logic                 flush_decode,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 halted,
  output logic [CNT_WIDTH-1:0] stall_cnt,
  output logic [CNT_WIDTH-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_FLUSH    = 2'd2,
    ST_HALT     = 2'd3
  } state_t;

  // Down-counter reload values: the detecting cycle is the first of the
  // sequence, so the state-held part lasts N-1 cycles.
  localparam logic [2:0] LU_RELOAD = 3'(LOAD_USE_CYCLES - 1);
  localparam logic [2:0] FL_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [2:0]           r_cnt;
  logic [2:0]           w_cnt_nxt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  logic w_lu;
  logic w_halting;
  logic w_branch;

  // x0 is hardwired to zero, so a load to x0 never creates a dependency.
  assign w_lu = id_valid & ex_is_load & ex_w_enable & (ex_rd_addr != 5'd0) &
                ((id_rs1_used & (id_rs1_addr == ex_rd_addr)) |
                 (id_rs2_used & (id_rs2_addr == ex_rd_addr)));

  assign w_halting = (r_state == ST_HALT) | wb_is_halt;
  assign w_branch  = ~w_halting & ex_br_taken;

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_RUN;
      r_cnt   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_halting) begin
      w_state_nxt = ST_HALT;
    end else if (ex_br_taken) begin
      // A taken branch cancels any pending load-use stall and restarts an
      // in-progress flush.
      if (FLUSH_CYCLES > 1) begin
        w_state_nxt = ST_FLUSH;
        w_cnt_nxt   = FL_RELOAD;
      end else begin
        w_state_nxt = ST_RUN;
        w_cnt_nxt   = 3'd0;
      end
    end else if (dmem_busy) begin
      // Whole pipe holds: state and counter freeze.
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
    end else begin
      unique case (r_state)
        ST_RUN: begin
          if (w_lu && (LOAD_USE_CYCLES > 1)) begin
            w_state_nxt = ST_LU_STALL;
            w_cnt_nxt   = LU_RELOAD;
          end
        end
        ST_LU_STALL, ST_FLUSH: begin
          // Leave on the cycle the counter would reach zero.
          if (r_cnt <= 3'd1) begin
            w_state_nxt = ST_RUN;
            w_cnt_nxt   = 3'd0;
          end else begin
            w_cnt_nxt = r_cnt - 3'd1;
          end
        end
        default: begin
          w_state_nxt = r_state;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Output logic (state plus current inputs). Everything is forced low while
  // reset is asserted so the pipe sees a clean zero even with live inputs.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_fetch    = 1'b0;
    stall_decode   = 1'b0;
    stall_execute  = 1'b0;
    is_data_hazard = 1'b0;
    flush_fetch    = 1'b0;
    flush_decode   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;
    halted         = 1'b0;
    if (rst) begin
      halted = (r_state == ST_HALT);
      if (w_halting) begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        stall_execute = 1'b1;
      end else if (ex_br_taken) begin
        redirect_valid = 1'b1;
        redirect_pc    = ex_br_target;
        flush_fetch    = 1'b1;
        flush_decode   = 1'b1;
        is_data_hazard = 1'b1;
      end else if (dmem_busy) begin
        stall_fetch   = 1'b1;
        stall_decode  = 1'b1;
        stall_execute = 1'b1;
        flush_fetch   = (r_state == ST_FLUSH);
        flush_decode  = (r_state == ST_FLUSH);
      end else begin
        unique case (r_state)
          ST_RUN: begin
            stall_fetch    = w_lu;
            stall_decode   = w_lu;
            is_data_hazard = w_lu;
          end
          ST_LU_STALL: begin
            stall_fetch    = 1'b1;
            stall_decode   = 1'b1;
            is_data_hazard = 1'b1;
          end
          ST_FLUSH: begin
            flush_fetch  = 1'b1;
            flush_decode = 1'b1;
          end
          default: begin
            stall_fetch = 1'b0;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Saturating performance counters
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      if (stall_fetch && (r_state != ST_HALT) && !(&r_stall_cnt)) begin
        r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
      if (w_branch && !(&r_flush_cnt)) begin
        r_flush_cnt <= r_flush_cnt + CNT_WIDTH'(1);
      end
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_hazard_controller.sv
module tb_hazard_controller;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs1_addr;
  logic        id_rs1_used;
  logic [4:0]  id_rs2_addr;
  logic        id_rs2_used;
  logic [4:0]  ex_rd_addr;
  logic        ex_w_enable;
  logic        ex_is_load;
  logic        ex_br_taken;
  logic [31:0] ex_br_target;
  logic        dmem_busy;
  logic        wb_is_halt;

  // per-instance outputs: 0 = defaults, 1 = LOAD_USE_CYCLES=3, 2 = LU=7/CNT_WIDTH=4
  logic sf0, sd0, se0, dh0, ff0, fd0, rv0, hl0;
  logic sf1, sd1, se1, dh1, ff1, fd1, rv1, hl1;
  logic sf2, sd2, se2, dh2, ff2, fd2, rv2, hl2;
  logic [31:0] pc0, pc1, pc2;
  logic [15:0] sc0, fc0, sc1, fc1;
  logic [3:0]  sc2, fc2;

  hazard_controller u_def (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_w_enable(ex_w_enable), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .dmem_busy(dmem_busy), .wb_is_halt(wb_is_halt),
    .stall_fetch(sf0), .stall_decode(sd0), .stall_execute(se0),
    .is_data_hazard(dh0), .flush_fetch(ff0), .flush_decode(fd0),
    .redirect_valid(rv0), .redirect_pc(pc0), .halted(hl0),
    .stall_cnt(sc0), .flush_cnt(fc0)
  );

  hazard_controller #(.LOAD_USE_CYCLES(3)) u_lu3 (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_w_enable(ex_w_enable), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .dmem_busy(dmem_busy), .wb_is_halt(wb_is_halt),
    .stall_fetch(sf1), .stall_decode(sd1), .stall_execute(se1),
    .is_data_hazard(dh1), .flush_fetch(ff1), .flush_decode(fd1),
    .redirect_valid(rv1), .redirect_pc(pc1), .halted(hl1),
    .stall_cnt(sc1), .flush_cnt(fc1)
  );

  hazard_controller #(.LOAD_USE_CYCLES(7), .CNT_WIDTH(4)) u_sat (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .id_rs1_addr(id_rs1_addr), .id_rs1_used(id_rs1_used),
    .id_rs2_addr(id_rs2_addr), .id_rs2_used(id_rs2_used),
    .ex_rd_addr(ex_rd_addr), .ex_w_enable(ex_w_enable), .ex_is_load(ex_is_load),
    .ex_br_taken(ex_br_taken), .ex_br_target(ex_br_target),
    .dmem_busy(dmem_busy), .wb_is_halt(wb_is_halt),
    .stall_fetch(sf2), .stall_decode(sd2), .stall_execute(se2),
    .is_data_hazard(dh2), .flush_fetch(ff2), .flush_decode(fd2),
    .redirect_valid(rv2), .redirect_pc(pc2), .halted(hl2),
    .stall_cnt(sc2), .flush_cnt(fc2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // output vector bits: sf sd se dh ff fd rv halted
  localparam logic [7:0] O_NONE    = 8'b0000_0000;
  localparam logic [7:0] O_LU      = 8'b1101_0000;
  localparam logic [7:0] O_BR      = 8'b0001_1110;
  localparam logic [7:0] O_FL      = 8'b0000_1100;
  localparam logic [7:0] O_BUSY_FL = 8'b1110_1100;
  localparam logic [7:0] O_HALTING = 8'b1110_0000;
  localparam logic [7:0] O_HALTED  = 8'b1110_0001;

  typedef struct {
    int          which;
    logic [7:0]  outs;
    logic [31:0] pc;
    logic [15:0] sc;
    logic [15:0] fc;
    bit          chk;
    string       name;
  } exp_t;

  exp_t q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // Monitor: every cycle an expectation is queued, compare at the falling edge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t        e;
      logic [7:0]  a_outs;
      logic [31:0] a_pc;
      logic [15:0] a_sc, a_fc;
      e = q.pop_front();
      case (e.which)
        1: begin
          a_outs = {sf1, sd1, se1, dh1, ff1, fd1, rv1, hl1};
          a_pc = pc1; a_sc = sc1; a_fc = fc1;
        end
        2: begin
          a_outs = {sf2, sd2, se2, dh2, ff2, fd2, rv2, hl2};
          a_pc = pc2; a_sc = {12'd0, sc2}; a_fc = {12'd0, fc2};
        end
        default: begin
          a_outs = {sf0, sd0, se0, dh0, ff0, fd0, rv0, hl0};
          a_pc = pc0; a_sc = sc0; a_fc = fc0;
        end
      endcase
      n_tests++;
      if (a_outs !== e.outs || a_pc !== e.pc) begin
        n_fail++;
        $display("FAIL %s outputs: got %b pc=%h, want %b pc=%h",
                 e.name, a_outs, a_pc, e.outs, e.pc);
      end
      if (e.chk) begin
        n_tests++;
        if (a_sc !== e.sc || a_fc !== e.fc) begin
          n_fail++;
          $display("FAIL %s counters: got stall=%0d flush=%0d, want stall=%0d flush=%0d",
                   e.name, a_sc, a_fc, e.sc, e.fc);
        end
      end
    end
  end

  task automatic push(input int which, input logic [7:0] outs, input logic [31:0] pc,
                      input logic [15:0] sc, input logic [15:0] fc, input bit chk,
                      input string name);
    exp_t e;
    e.which = which; e.outs = outs; e.pc = pc;
    e.sc = sc; e.fc = fc; e.chk = chk; e.name = name;
    q.push_back(e);
  endtask

  // Queue this cycle's expectation, then advance to just after the next edge.
  task automatic cyc(input int which, input logic [7:0] outs, input logic [31:0] pc,
                     input logic [15:0] sc, input logic [15:0] fc, input bit chk,
                     input string name);
    push(which, outs, pc, sc, fc, chk, name);
    @(posedge clk);
    #1;
  endtask

  task automatic clr_inputs();
    id_valid = 0; id_rs1_addr = 0; id_rs1_used = 0; id_rs2_addr = 0; id_rs2_used = 0;
    ex_rd_addr = 0; ex_w_enable = 0; ex_is_load = 0; ex_br_taken = 0;
    ex_br_target = 0; dmem_busy = 0; wb_is_halt = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic hazard_rs2(input logic [4:0] r);
    ex_is_load = 1; ex_w_enable = 1; ex_rd_addr = r;
    id_valid = 1; id_rs2_used = 1; id_rs2_addr = r;
  endtask

  initial begin
    rst = 1'b0;
    clr_inputs();
    repeat (2) @(posedge clk);
    #1;

    // reset state with live inputs: everything held low
    ex_br_taken = 1; ex_br_target = 32'h123; dmem_busy = 1; wb_is_halt = 1;
    cyc(0, O_NONE, 32'h0, 16'd0, 16'd0, 1, "reset_def");
    cyc(2, O_NONE, 32'h0, 16'd0, 16'd0, 1, "reset_sat");

    // ---- load-use, default parameters ----
    do_reset();
    cyc(0, O_NONE, 32'h0, 16'd0, 16'd0, 1, "idle");
    hazard_rs2(5'd5);
    cyc(0, O_LU, 32'h0, 16'd0, 16'd0, 1, "lu_rs2");
    clr_inputs(); id_valid = 1; id_rs2_used = 1; id_rs2_addr = 5'd5;
    cyc(0, O_NONE, 32'h0, 16'd1, 16'd0, 1, "lu_one_cycle");
    hazard_rs2(5'd0);
    cyc(0, O_NONE, 32'h0, 16'd1, 16'd0, 1, "lu_x0");
    clr_inputs();
    ex_is_load = 1; ex_w_enable = 1; ex_rd_addr = 5'd7;
    id_valid = 1; id_rs1_used = 1; id_rs1_addr = 5'd7;
    cyc(0, O_LU, 32'h0, 16'd1, 16'd0, 1, "lu_rs1");
    id_valid = 0;
    cyc(0, O_NONE, 32'h0, 16'd2, 16'd0, 1, "lu_id_invalid");
    id_valid = 1; ex_w_enable = 0;
    cyc(0, O_NONE, 32'h0, 16'd2, 16'd0, 1, "lu_no_wen");

    // ---- load-use, LOAD_USE_CYCLES=3 ----
    do_reset();
    hazard_rs2(5'd5);
    cyc(1, O_LU, 32'h0, 16'd0, 16'd0, 1, "lu3_c1");
    clr_inputs();
    cyc(1, O_LU, 32'h0, 16'd1, 16'd0, 1, "lu3_c2");
    cyc(1, O_LU, 32'h0, 16'd2, 16'd0, 1, "lu3_c3");
    cyc(1, O_NONE, 32'h0, 16'd3, 16'd0, 1, "lu3_done");

    // ---- taken branch beats load-use ----
    do_reset();
    hazard_rs2(5'd5);
    ex_br_taken = 1; ex_br_target = 32'h0000_0100;
    cyc(0, O_BR, 32'h100, 16'd0, 16'd0, 1, "br_c1");
    clr_inputs();
    cyc(0, O_FL, 32'h0, 16'd0, 16'd1, 1, "br_c2");
    cyc(0, O_NONE, 32'h0, 16'd0, 16'd1, 1, "br_done");

    // ---- dmem_busy in the middle of a flush ----
    do_reset();
    ex_br_taken = 1; ex_br_target = 32'h0000_0040;
    cyc(0, O_BR, 32'h40, 16'd0, 16'd0, 1, "busy_br");
    clr_inputs(); dmem_busy = 1;
    for (int i = 0; i < 4; i++) begin
      cyc(0, O_BUSY_FL, 32'h0, 16'(i), 16'd1, 1, "busy_hold");
    end
    dmem_busy = 0;
    cyc(0, O_FL, 32'h0, 16'd4, 16'd1, 1, "busy_last_flush");
    cyc(0, O_NONE, 32'h0, 16'd4, 16'd1, 1, "busy_done");

    // ---- halt, then branch ignored, then async reset ----
    do_reset();
    wb_is_halt = 1;
    cyc(0, O_HALTING, 32'h0, 16'd0, 16'd0, 1, "halt_wb");
    wb_is_halt = 0; ex_br_taken = 1; ex_br_target = 32'h0000_0080;
    cyc(0, O_HALTED, 32'h0, 16'd1, 16'd0, 1, "halt_br_ignored");
    clr_inputs(); hazard_rs2(5'd3);
    cyc(0, O_HALTED, 32'h0, 16'd1, 16'd0, 1, "halt_sticky1");
    clr_inputs();
    cyc(0, O_HALTED, 32'h0, 16'd1, 16'd0, 1, "halt_sticky2");
    ex_br_taken = 1;
    #2;
    rst = 1'b0;
    cyc(0, O_NONE, 32'h0, 16'd0, 16'd0, 1, "async_reset");

    // ---- stall counter saturation, CNT_WIDTH=4 ----
    do_reset();
    hazard_rs2(5'd9);
    for (int i = 0; i < 21; i++) begin
      cyc(2, O_LU, 32'h0, 16'((i > 15) ? 15 : i), 16'd0, 1, "sat_stall");
    end
    clr_inputs();
    cyc(2, O_NONE, 32'h0, 16'd15, 16'd0, 1, "sat_hold");

    for (int i = 0; i < 20 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
